// File: rtl/tpm_capture_fifo.sv
// tpm_capture_fifo
// Captures one {addr_lo, data} record per decoded TPM read (rising edge of
// in_done). The records go into a small circular buffer. They are then
// replayed one byte at a time to a ready/valid serial transmitter.
// All state changes on the falling edge of lpc_clk. lpc_reset is an
// asynchronous, active-low reset.
module tpm_capture_fifo #(
  parameter int DEPTH     = 16,   // record slots, power of two, 2..256
  parameter bit WITH_ADDR = 1'b1  // 1: emit addr byte then data byte; 0: data only
) (
  input  logic                    lpc_clk,
  input  logic                    lpc_reset,
  input  logic                    in_done,
  input  logic [15:0]             in_addr,
  input  logic [7:0]              in_data,
  output logic [7:0]              out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_overflow,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EMIT_ADDR = 2'd1,
    ST_EMIT_DATA = 2'd2
  } state_t;

  // The first state entered for each record depends on whether the address
  // byte is sent.
  localparam state_t FIRST_EMIT = WITH_ADDR ? ST_EMIT_ADDR : ST_EMIT_DATA;

  // Only the low address byte goes into a record.
  logic [7:0] unused_addr_hi;
  assign unused_addr_hi = in_addr[15:8];

  state_t          state_reg;
  state_t          state_next;
  logic            done_prev_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic            overflow_reg;
  logic [7:0]      drop_count_reg;
  logic [15:0]     mem [DEPTH];
  logic [15:0]     rd_rec_reg;

  logic            capture;
  logic            full;
  logic            wr_en;
  logic            drop;
  logic            pop;
  logic            more;
  logic            load_en;
  logic [AW-1:0]   load_idx;
  logic [PW-1:0]   fill_int;

  // The pointers carry one extra wrap bit. This keeps full (fill == DEPTH)
  // distinct from empty (fill == 0), including after the pointers wrap.
  assign fill_int = wr_ptr_reg - rd_ptr_reg;
  assign full     = (fill_int == PW'(DEPTH));
  assign capture  = in_done & ~done_prev_reg;
  assign wr_en    = capture & ~full;
  // When the FIFO is full, a pop on the same edge does not save the record.
  assign drop     = capture & full;
  assign pop      = (state_reg == ST_EMIT_DATA) & out_ready;
  // Records left after this pop. A record captured on this same edge is not
  // counted, because it cannot be read until the next edge.
  assign more     = (fill_int > PW'(1));
  assign fill     = fill_int;

  // Load the next record into the output register. This happens when
  // leaving IDLE, or when popping with at least one more record stored.
  always_comb begin
    load_en  = 1'b0;
    load_idx = rd_ptr_reg[AW-1:0];
    if (state_reg == ST_IDLE && fill_int != '0) begin
      load_en  = 1'b1;
      load_idx = rd_ptr_reg[AW-1:0];
    end else if (pop && more) begin
      load_en  = 1'b1;
      load_idx = rd_ptr_reg[AW-1:0] + AW'(1);
    end
  end

  // Edge detector and circular-buffer pointers.
  always_ff @(negedge lpc_clk or negedge lpc_reset) begin
    if (!lpc_reset) begin
      done_prev_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      done_prev_reg <= in_done;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  // Record storage write port. It has no reset: stale contents are never
  // read, because reset clears the pointers.
  always_ff @(negedge lpc_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= {in_addr[7:0], in_data};
    end
  end

  // Registered read port. It holds the record being emitted until the next
  // load.
  always_ff @(negedge lpc_clk) begin
    if (load_en) begin
      rd_rec_reg <= mem[load_idx];
    end
  end

  // Sticky overflow flag and saturating drop counter. If a drop and a clear
  // happen on the same edge, the drop wins.
  always_ff @(negedge lpc_clk or negedge lpc_reset) begin
    if (!lpc_reset) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (clr_overflow) begin
        drop_count_reg <= 8'd1;
      end else if (drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end else if (clr_overflow) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

  // Output FSM state register.
  always_ff @(negedge lpc_clk or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fill_int != '0) begin
          state_next = FIRST_EMIT;
        end
      end
      ST_EMIT_ADDR: begin
        if (out_ready) begin
          state_next = ST_EMIT_DATA;
        end
      end
      ST_EMIT_DATA: begin
        if (out_ready) begin
          state_next = more ? FIRST_EMIT : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output FSM outputs. out_byte is decoded from the state, so an
  // asynchronous reset forces it to zero at once.
  always_comb begin
    out_valid = 1'b0;
    out_byte  = 8'd0;
    case (state_reg)
      ST_EMIT_ADDR: begin
        out_valid = 1'b1;
        out_byte  = rd_rec_reg[15:8];
      end
      ST_EMIT_DATA: begin
        out_valid = 1'b1;
        out_byte  = rd_rec_reg[7:0];
      end
      default: begin
        out_valid = 1'b0;
        out_byte  = 8'd0;
      end
    endcase
  end

endmodule
